fifo_ctrl_ratio: RTL
====================

FIFO_CTRL_RATIO -- requirements
Module: fifo_ctrl_ratio

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: address width; DEPTH = 2**ADDR_WIDTH slots.
REQ-002 Parameter RATIO, default 2: slots consumed per accepted write; power of two, 1 <= RATIO <= DEPTH.
REQ-003 Parameter AF_LEVEL, default DEPTH-4: almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous flush request.
REQ-007 rd  input  1  read request, one slot.
REQ-008 wr  input  1  write request, RATIO slots.
REQ-009 w_addr  output  ADDR_WIDTH  base slot of the current write; lane k writes slot (w_addr+k) mod DEPTH, k = 0..RATIO-1.
REQ-010 r_addr  output  ADDR_WIDTH  slot to be read.
REQ-011 count  output  ADDR_WIDTH+1  occupied slots, 0..DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 full  output  1  count == DEPTH.
REQ-014 wr_ready  output  1  DEPTH - count >= RATIO (a write is accepted).
REQ-015 almost_full  output  1  count >= AF_LEVEL.
REQ-016 overflow  output  1  sticky: a write was refused.
REQ-017 underflow  output  1  sticky: a read was refused.

Function
REQ-018 State SHALL be wr_ptr, rd_ptr (ADDR_WIDTH bits each), count, overflow and underflow registers; all other outputs SHALL be combinational decodes of these registers only.
REQ-019 w_addr SHALL equal wr_ptr; r_addr SHALL equal rd_ptr.
REQ-020 rd_acc SHALL equal rd & ~empty; wr_acc SHALL equal wr & wr_ready; each is evaluated on pre-edge state, and wr_acc SHALL NOT depend on rd.
REQ-021 On rd_acc, rd_ptr SHALL advance by 1 modulo DEPTH at the next edge.
REQ-022 On wr_acc, wr_ptr SHALL advance by RATIO modulo DEPTH at the next edge; wr_ptr therefore stays a multiple of RATIO.
REQ-023 count_next SHALL equal count + (wr_acc ? RATIO : 0) - (rd_acc ? 1 : 0), computed at ADDR_WIDTH+1 bits, and SHALL never leave 0..DEPTH.
REQ-024 Simultaneous rd_acc and wr_acc SHALL apply both pointer updates and a net count change of RATIO-1 in the same cycle.
REQ-025 A read and a write in the same cycle on a full FIFO SHALL accept the read and refuse the write when RATIO > 0 free slots are unavailable; on an empty FIFO they SHALL accept the write and refuse the read.
REQ-026 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; a write whose lanes span the wrap is impossible because of alignment (REQ-022).
REQ-027 wr & ~wr_ready SHALL set overflow at the next edge; rd & empty SHALL set underflow at the next edge; both flags hold until reset or clear.
REQ-028 clear, when reset is low, SHALL at the next edge set wr_ptr=0, rd_ptr=0, count=0 and both sticky flags to 0, and SHALL override rd and wr in that cycle.
REQ-029 With RATIO == 1, the block SHALL behave as a conventional single-slot FIFO controller.

Reset
REQ-030 reset SHALL take priority over clear, rd and wr.
REQ-031 After a reset edge: w_addr=0, r_addr=0, count=0, empty=1, full=0, wr_ready=1, almost_full=0, overflow=0, underflow=0.
REQ-032 reset asserted mid-operation SHALL discard all contents and in-flight requests in that cycle, with no partial pointer update.

Verification (ADDR_WIDTH=4, RATIO=2, AF_LEVEL=12 unless noted)
REQ-033 After reset, 8 consecutive wr -> w_addr steps 0,2,..,14, then returns to 0; count=16; full=1; wr_ready=0; almost_full=1 from count 12 onward.
REQ-034 At count=15 (fill, then 1 rd), wr -> refused; overflow=1; count stays 15; after 1 more rd (count=14), wr_ready=1.
REQ-035 At count=16, rd+wr in the same cycle -> read accepted, write refused; count=15; overflow=1.
REQ-036 On an empty FIFO, rd+wr in the same cycle -> write only; count=2; underflow=1; r_addr=0.
REQ-037 At count=5, rd+wr in the same cycle -> count=6; rd_ptr+1 and wr_ptr+2. Then clear together with wr -> all pointers, count and flags return to 0, and the write is ignored.
REQ-038 Random rd/wr for 10k cycles against a reference queue model -> count, empty, full and pointers match every cycle; repeat with RATIO=1 and RATIO=4.

Source files
------------

// File: rtl/fifo_ctrl_ratio.sv
// fifo_ctrl_ratio: pointer/occupancy controller for a FIFO whose writes
// consume RATIO consecutive slots and whose reads release one slot.
// Only the pointers, the occupancy count and the two sticky error flags
// are stored. Every other output is decoded from those registers.
// Because RATIO is a power of two, wr_ptr stays RATIO-aligned. A write's
// lanes therefore never straddle the DEPTH-1 -> 0 wrap.
module fifo_ctrl_ratio #(
    parameter int ADDR_WIDTH = 4,
    parameter int RATIO      = 2,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  rd,
    input  logic                  wr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  wr_ready,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0]         C_RATIO    = CW'(RATIO);
    localparam logic [CW-1:0]         C_AF_LEVEL = CW'(AF_LEVEL);
    // Highest count at which RATIO free slots remain.
    localparam logic [CW-1:0]         C_WR_MAX   = CW'(DEPTH - RATIO);
    // With RATIO == DEPTH, a write advances the pointer by a full lap,
    // which leaves it unchanged modulo DEPTH.
    localparam logic [ADDR_WIDTH-1:0] C_WR_STEP  = ADDR_WIDTH'(RATIO % DEPTH);
    localparam logic [ADDR_WIDTH-1:0] C_RD_STEP  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_ready;
    logic                  w_almost_full;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_wr_refused;
    logic                  w_rd_refused;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
    logic [CW-1:0]         w_count_next;
    logic                  w_overflow_next;
    logic                  w_underflow_next;

    // Status decode from the stored occupancy only.
    always_comb begin
        w_empty       = (r_count == '0);
        w_full        = (r_count == C_DEPTH);
        w_wr_ready    = (r_count <= C_WR_MAX);
        w_almost_full = (r_count >= C_AF_LEVEL);
    end

    // Request acceptance uses pre-edge state. A write never waits on a
    // same-cycle read to make room.
    always_comb begin
        w_rd_acc     = rd & ~w_empty;
        w_wr_acc     = wr & w_wr_ready;
        w_rd_refused = rd & w_empty;
        w_wr_refused = wr & ~w_wr_ready;
    end

    // Next pointer, occupancy and flag values when no reset or clear applies.
    always_comb begin
        w_wr_ptr_next    = r_wr_ptr;
        w_rd_ptr_next    = r_rd_ptr;
        w_count_next     = r_count;
        w_overflow_next  = r_overflow | w_wr_refused;
        w_underflow_next = r_underflow | w_rd_refused;
        if (w_wr_acc) begin
            w_wr_ptr_next = r_wr_ptr + C_WR_STEP;
        end
        if (w_rd_acc) begin
            w_rd_ptr_next = r_rd_ptr + C_RD_STEP;
        end
        // Both terms are gated by acceptance, so the sum stays in 0..DEPTH.
        w_count_next = r_count
                     + (w_wr_acc ? C_RATIO : '0)
                     - (w_rd_acc ? CW'(1) : '0);
    end

    // State register. Reset beats clear, and clear beats any request
    // in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
        end
    end

    // Output mapping.
    always_comb begin
        w_addr      = r_wr_ptr;
        r_addr      = r_rd_ptr;
        count       = r_count;
        empty       = w_empty;
        full        = w_full;
        wr_ready    = w_wr_ready;
        almost_full = w_almost_full;
        overflow    = r_overflow;
        underflow   = r_underflow;
    end

endmodule
